fetch_ctrl: RTL

Fetch-stage controller that drives the program counter's command port (`pc_valid`/`pc_mode`/`pc_data`) and consumes its `pc_out`/`jump_finish` outputs. It issues sequential increments, converts execute-stage redirects into absolute or relative PC loads, and presents fetched instructions to decode. It blocks while a PC load is settling and holds one in-flight instruction across decode stalls.

---
 rtl/fetch_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Purpose:
//   Fetch-stage controller. Drives the program counter's command port with
//   sequential increments, turns execute-stage redirects into absolute or
//   relative PC loads, and presents fetched instructions to decode. After a
//   redirect it idles in WAIT until the PC reports the load has settled. A
//   one-entry buffer holds the in-flight instruction across decode stalls.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   pc_in            current PC value (from PC pc_out)
//   jump_finish      PC pulse: a load has settled
//   pc_valid         PC command strobe
//   pc_mode          0 incr, 1 absolute load, 2 relative add, 3 idle
//   pc_data          load value or relative offset
//   imem_addr        instruction memory address (= pc_in)
//   imem_rdata       instruction memory data, one cycle after the address
//   stall            decode cannot accept an instruction
//   redir_valid      execute redirect request
//   redir_rel        1: target is an offset from redir_pc, 0: absolute
//   redir_pc         PC of the redirecting instruction
//   redir_target     target address or offset
//   redir_ready      redirect accepted this cycle
//   inst_valid       instruction available to decode
//   inst, inst_pc    instruction word and its address
// -----------------------------------------------------------------------------
module fetch_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_in,
   input  logic        jump_finish,
   output logic        pc_valid,
   output logic [1:0]  pc_mode,
   output logic [31:0] pc_data,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic        redir_rel,
   input  logic [31:0] redir_pc,
   input  logic [31:0] redir_target,
   output logic        redir_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_WAIT  = 1'b1
   } state_t;

   localparam logic [1:0] MODE_INCR = 2'd0;
   localparam logic [1:0] MODE_ABS  = 2'd1;
   localparam logic [1:0] MODE_REL  = 2'd2;
   localparam logic [1:0] MODE_IDLE = 2'd3;

   state_t      state_q, state_d;
   logic        issued_q, issued_d;
   logic [31:0] issued_pc_q, issued_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        flush;

   // The PC adds its own current value in relative mode, so the offset sent
   // must cancel pc_in; the final PC lands on redir_pc + redir_target
   // (all modulo 2^32).
   function automatic logic [31:0] rel_delta(input logic [31:0] base,
                                             input logic [31:0] offset,
                                             input logic [31:0] cur_pc);
      logic signed [31:0] delta;
      delta = $signed(base) + $signed(offset) - $signed(cur_pc);
      return delta;
   endfunction

   assign imem_addr = pc_in;

   // Command / next-state logic
   always_comb begin
      state_d     = state_q;
      issued_d    = 1'b0;
      issued_pc_d = issued_pc_q;
      pc_valid    = 1'b0;
      pc_mode     = MODE_IDLE;
      pc_data     = 32'd0;
      redir_ready = 1'b0;
      flush       = 1'b0;

      // While reset is held the command port stays idle even though the
      // registers already read as FETCH with an empty buffer.
      if (rstn) begin
         case (state_q)
            S_FETCH: begin
               if (redir_valid) begin
                  redir_ready = 1'b1;
                  pc_valid    = 1'b1;
                  flush       = 1'b1;
                  state_d     = S_WAIT;
                  if (redir_rel) begin
                     pc_mode = MODE_REL;
                     pc_data = rel_delta(redir_pc, redir_target, pc_in);
                  end else begin
                     pc_mode = MODE_ABS;
                     pc_data = redir_target;
                  end
               end else if (!stall && !hold_valid_q) begin
                  pc_valid    = 1'b1;
                  pc_mode     = MODE_INCR;
                  issued_d    = 1'b1;
                  issued_pc_d = pc_in;
               end
            end
            S_WAIT: begin
               if (jump_finish) begin
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   // Decode-side output and stall buffer
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_inst_d  = hold_inst_q;
      hold_pc_d    = hold_pc_q;

      inst_valid = (state_q == S_FETCH) && (hold_valid_q || issued_q) && !flush;

      if (hold_valid_q) begin
         inst    = hold_inst_q;
         inst_pc = hold_pc_q;
      end else if (issued_q) begin
         inst    = imem_rdata;
         inst_pc = issued_pc_q;
      end else begin
         inst    = 32'd0;
         inst_pc = 32'd0;
      end

      if (flush) begin
         hold_valid_d = 1'b0;
      end else if (hold_valid_q) begin
         // Held word is always presented in FETCH; it leaves once decode takes it.
         if (!stall) begin
            hold_valid_d = 1'b0;
         end
      end else if (issued_q && stall) begin
         // imem data is only valid for one cycle, so park it here.
         hold_valid_d = 1'b1;
         hold_inst_d  = imem_rdata;
         hold_pc_d    = issued_pc_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_FETCH;
         issued_q     <= 1'b0;
         issued_pc_q  <= 32'd0;
         hold_valid_q <= 1'b0;
         hold_inst_q  <= 32'd0;
         hold_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         issued_q     <= issued_d;
         issued_pc_q  <= issued_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_inst_q  <= hold_inst_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

endmodule
